// File: rtl/nyan_song_sequencer.sv
// Nyan song sequencer: tick-driven song position, sync-ROM step fetch,
// per-voice note/octave registers and decaying volume envelopes.
module nyan_song_sequencer #(
  parameter int unsigned SONG_LEN       = 288,
  parameter int unsigned TICKS_PER_STEP = 6,
  parameter int unsigned MEL_SHIFT      = 3,
  parameter int unsigned BASS_SHIFT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_i,
  input  logic        run_i,
  input  logic        restart_i,
  output logic        rom_rd_o,
  output logic [8:0]  rom_addr_o,
  input  logic [11:0] rom_data_i,
  output logic [2:0]  mel_note_o,
  output logic [1:0]  mel_oct_o,
  output logic [2:0]  bass_note_o,
  output logic [1:0]  bass_oct_o,
  output logic [5:0]  mel_vol_o,
  output logic [5:0]  bass_vol_o,
  output logic [8:0]  songpos_o,
  output logic        step_o
);

  localparam int unsigned CTR_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [8:0]       LAST_POS  = 9'(SONG_LEN - 1);
  localparam logic [CTR_W-1:0] LAST_TICK = CTR_W'(TICKS_PER_STEP - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    LATCH
  } state_t;

  state_t           state;
  logic [CTR_W-1:0] tick_ctr;
  logic [11:0]      rom_word;

  logic [8:0] pos_next;
  logic [5:0] mel_vol_dec;
  logic [5:0] bass_vol_dec;
  logic       tick_accept;
  logic       step_tick;

  // Next song position and the floored per-tick envelope decay values.
  always_comb begin
    pos_next     = (songpos_o == LAST_POS) ? '0 : songpos_o + 9'd1;
    mel_vol_dec  = mel_vol_o  - (mel_vol_o  >> MEL_SHIFT);
    bass_vol_dec = bass_vol_o - (bass_vol_o >> BASS_SHIFT);
    tick_accept  = (state == IDLE) && tick_i && run_i;
    step_tick    = tick_accept && (tick_ctr == LAST_TICK);
  end

  // Sequencer FSM; restart_i shares the reset path so an in-flight fetch is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || restart_i) begin
      state       <= IDLE;
      tick_ctr    <= '0;
      rom_word    <= '0;
      rom_rd_o    <= 1'b0;
      rom_addr_o  <= '0;
      mel_note_o  <= '0;
      mel_oct_o   <= '0;
      bass_note_o <= '0;
      bass_oct_o  <= '0;
      mel_vol_o   <= '0;
      bass_vol_o  <= '0;
      songpos_o   <= LAST_POS;
      step_o      <= 1'b0;
    end else begin
      rom_rd_o <= 1'b0;
      step_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (step_tick) begin
            tick_ctr   <= '0;
            rom_addr_o <= pos_next;
            rom_rd_o   <= 1'b1;
            state      <= FETCH;
          end else if (tick_accept) begin
            tick_ctr   <= tick_ctr + CTR_W'(1);
            mel_vol_o  <= mel_vol_dec;
            bass_vol_o <= bass_vol_dec;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          rom_word <= rom_data_i;
          state    <= LATCH;
        end
        LATCH: begin
          mel_oct_o   <= rom_word[10:9];
          mel_note_o  <= rom_word[8:6];
          bass_oct_o  <= rom_word[4:3];
          bass_note_o <= rom_word[2:0];
          if (rom_word[11]) mel_vol_o  <= 6'd63;
          if (rom_word[5])  bass_vol_o <= 6'd63;
          songpos_o <= rom_addr_o;
          step_o    <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nyan_song_sequencer.sv
// Self-checking bench for nyan_song_sequencer with a per-edge reference model.
module tb_nyan_song_sequencer;

  localparam int SONG_LEN   = 288;
  localparam int TPS        = 6;
  localparam int MEL_SHIFT  = 3;
  localparam int BASS_SHIFT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_i = 1'b0;
  logic        run_i = 1'b0;
  logic        restart_i = 1'b0;
  logic        rom_rd_o;
  logic [8:0]  rom_addr_o;
  logic [11:0] rom_data_i = '0;
  logic [2:0]  mel_note_o;
  logic [1:0]  mel_oct_o;
  logic [2:0]  bass_note_o;
  logic [1:0]  bass_oct_o;
  logic [5:0]  mel_vol_o;
  logic [5:0]  bass_vol_o;
  logic [8:0]  songpos_o;
  logic        step_o;

  int vectors = 0;
  int miscompares = 0;

  nyan_song_sequencer #(
    .SONG_LEN(SONG_LEN),
    .TICKS_PER_STEP(TPS),
    .MEL_SHIFT(MEL_SHIFT),
    .BASS_SHIFT(BASS_SHIFT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick_i(tick_i),
    .run_i(run_i),
    .restart_i(restart_i),
    .rom_rd_o(rom_rd_o),
    .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i),
    .mel_note_o(mel_note_o),
    .mel_oct_o(mel_oct_o),
    .bass_note_o(bass_note_o),
    .bass_oct_o(bass_oct_o),
    .mel_vol_o(mel_vol_o),
    .bass_vol_o(bass_vol_o),
    .songpos_o(songpos_o),
    .step_o(step_o)
  );

  always #5 clk = ~clk;

  // Song ROM: synchronous read, data valid the cycle after the read strobe.
  logic [11:0] rom [SONG_LEN];
  always @(posedge clk) if (rom_rd_o) rom_data_i <= rom[rom_addr_o];

  // Reference model: song-level quantities, a fetch in flight counts down 3 edges.
  int m_pos, m_ctr, m_addr, m_pend, m_mv, m_bv, m_mn, m_mo, m_bn, m_bo;
  bit m_step, m_rd;

  task automatic model_edge();
    logic [11:0] w;
    m_step = 1'b0;
    if (!rst_n || restart_i) begin
      m_pos = SONG_LEN - 1; m_ctr = 0; m_addr = 0; m_pend = 0;
      m_mv = 0; m_bv = 0; m_mn = 0; m_mo = 0; m_bn = 0; m_bo = 0;
    end else if (m_pend != 0) begin
      m_pend--;
      if (m_pend == 0) begin
        w = rom[m_addr];
        m_pos = m_addr;
        m_mo = int'(w[10:9]); m_mn = int'(w[8:6]);
        m_bo = int'(w[4:3]);  m_bn = int'(w[2:0]);
        if (w[11]) m_mv = 63;
        if (w[5])  m_bv = 63;
        m_step = 1'b1;
      end
    end else if (tick_i && run_i) begin
      if (m_ctr + 1 == TPS) begin
        m_ctr = 0;
        m_addr = (m_pos + 1) % SONG_LEN;
        m_pend = 3;
      end else begin
        m_ctr++;
        m_mv = m_mv - m_mv / (1 << MEL_SHIFT);
        m_bv = m_bv - m_bv / (1 << BASS_SHIFT);
      end
    end
    m_rd = (m_pend == 3);
  endtask

  function automatic logic [41:0] exp_vec();
    return {m_rd, 9'(m_addr), 3'(m_mn), 2'(m_mo), 3'(m_bn), 2'(m_bo),
            6'(m_mv), 6'(m_bv), 9'(m_pos), m_step};
  endfunction

  logic [41:0] dut_vec;
  assign dut_vec = {rom_rd_o, rom_addr_o, mel_note_o, mel_oct_o, bass_note_o, bass_oct_o,
                    mel_vol_o, bass_vol_o, songpos_o, step_o};

  // One clock with the given tick level; outputs are sampled 1 time unit after the edge.
  task automatic clk_step(input bit t);
    tick_i = t;
    @(posedge clk);
    model_edge();
    #1;
    tick_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clk_step(1'b1);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL reset_vec: got %h expected %h", dut_vec, exp_vec());
      end
    end
    vectors++;
    if (songpos_o !== 9'd287 || mel_vol_o !== 6'd0 || bass_vol_o !== 6'd0 ||
        rom_rd_o !== 1'b0 || rom_addr_o !== 9'd0 || step_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got pos=%0d mv=%0d bv=%0d rd=%b addr=%0d step=%b expected 287 0 0 0 0 0",
               songpos_o, mel_vol_o, bass_vol_o, rom_rd_o, rom_addr_o, step_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_step();
    rom[0] = 12'b1_10_101_1_01_011;
    for (int k = 0; k < 6; k++) begin
      clk_step(1'b1);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL first_tick%0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      if (k < 5) begin
        for (int c = 0; c < 3; c++) begin
          clk_step(1'b0);
          vectors++;
          if (dut_vec !== exp_vec()) begin
            miscompares++; $display("FAIL first_gap: got %h expected %h", dut_vec, exp_vec());
          end
        end
      end
    end
    vectors++;
    if (rom_rd_o !== 1'b1 || rom_addr_o !== 9'd0) begin
      miscompares++; $display("FAIL first_fetch: got rd=%b addr=%0d expected 1 0", rom_rd_o, rom_addr_o);
    end
    for (int c = 0; c < 3; c++) begin
      clk_step(1'b0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL first_latency: got %h expected %h", dut_vec, exp_vec());
      end
      if (c == 1) begin
        vectors++;
        if (step_o !== 1'b0) begin
          miscompares++; $display("FAIL first_early_step: got %b expected 0", step_o);
        end
      end
    end
    vectors++;
    if (step_o !== 1'b1 || songpos_o !== 9'd0 || mel_vol_o !== 6'd63 || bass_vol_o !== 6'd63 ||
        mel_note_o !== 3'd5 || mel_oct_o !== 2'd2 || bass_note_o !== 3'd3 || bass_oct_o !== 2'd1) begin
      miscompares++;
      $display("FAIL first_latch: got step=%b pos=%0d mv=%0d bv=%0d mn=%0d mo=%0d bn=%0d bo=%0d expected 1 0 63 63 5 2 3 1",
               step_o, songpos_o, mel_vol_o, bass_vol_o, mel_note_o, mel_oct_o, bass_note_o, bass_oct_o);
    end
  endtask

  task automatic test_decay();
    int mel_tab [5]  = '{56, 49, 43, 38, 34};
    int bass_tab [5] = '{48, 36, 27, 21, 16};
    for (int k = 0; k < 5; k++) begin
      clk_step(1'b1);
      vectors++;
      if (mel_vol_o !== 6'(mel_tab[k]) || bass_vol_o !== 6'(bass_tab[k])) begin
        miscompares++;
        $display("FAIL decay%0d: got mv=%0d bv=%0d expected %0d %0d", k, mel_vol_o, bass_vol_o,
                 mel_tab[k], bass_tab[k]);
      end
      for (int c = 0; c < 3; c++) begin
        clk_step(1'b0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
          miscompares++; $display("FAIL decay_gap: got %h expected %h", dut_vec, exp_vec());
        end
      end
    end
  endtask

  task automatic test_pause();
    run_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      for (int c = 0; c < 4; c++) begin
        clk_step(c == 0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
          miscompares++; $display("FAIL pause: got %h expected %h", dut_vec, exp_vec());
        end
      end
    end
    vectors++;
    if (mel_vol_o !== 6'd34 || bass_vol_o !== 6'd16 || songpos_o !== 9'd0 || rom_rd_o !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_hold: got mv=%0d bv=%0d pos=%0d rd=%b expected 34 16 0 0",
               mel_vol_o, bass_vol_o, songpos_o, rom_rd_o);
    end
    run_i = 1'b1;
    clk_step(1'b1);
    vectors++;
    if (rom_rd_o !== 1'b1 || rom_addr_o !== 9'd1) begin
      miscompares++; $display("FAIL pause_resume: got rd=%b addr=%0d expected 1 1", rom_rd_o, rom_addr_o);
    end
    for (int c = 0; c < 4; c++) begin
      clk_step(1'b0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL pause_step: got %h expected %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    int steps = 0;
    int wraps = 0;
    int gap = 4;
    int c = 0;
    for (int i = 0; i < SONG_LEN; i++) rom[i] = 12'($urandom);
    run_i = 1'b1;
    for (int cyc = 0; cyc < 12000 && steps < SONG_LEN + 2; cyc++) begin
      clk_step(c == 0);
      c++;
      if (c >= gap) begin c = 0; gap = $urandom_range(4, 7); end
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL wrap_vec cyc%0d: got %h expected %h", cyc, dut_vec, exp_vec());
      end
      if (songpos_o >= 9'd288) begin
        vectors++; miscompares++; $display("FAIL wrap_range: got pos=%0d expected <288", songpos_o);
      end
      if (m_step) begin
        steps++;
        if (m_pos == 0) begin
          wraps++;
          vectors++;
          if (songpos_o !== 9'd0 || step_o !== 1'b1) begin
            miscompares++; $display("FAIL wrap_zero: got pos=%0d step=%b expected 0 1", songpos_o, step_o);
          end
        end
      end
    end
    vectors++;
    if (steps < SONG_LEN + 2 || wraps == 0) begin
      miscompares++; $display("FAIL wrap_budget: got steps=%0d wraps=%0d expected %0d >=1", steps, wraps, SONG_LEN + 2);
    end
  endtask

  task automatic test_random();
    int gap = 4;
    int c = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 49) == 0) run_i = ~run_i;
      restart_i = ($urandom_range(0, 399) == 0);
      clk_step(c == 0);
      restart_i = 1'b0;
      c++;
      if (c >= gap) begin c = 0; gap = $urandom_range(4, 8); end
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL random cyc%0d: got %h expected %h", cyc, dut_vec, exp_vec());
      end
    end
    run_i = 1'b1;
    for (int c2 = 0; c2 < 6; c2++) begin
      clk_step(1'b0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL random_drain: got %h expected %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_restart();
    bit found;
    for (int i = 0; i < SONG_LEN; i++) rom[i] = 12'($urandom) | 12'h820;
    run_i = 1'b1;
    for (int ph = 0; ph < 3; ph++) begin
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
        clk_step((c % 4) == 0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
          miscompares++; $display("FAIL restart_seek%0d: got %h expected %h", ph, dut_vec, exp_vec());
        end
        if (m_pend == 3) found = 1'b1;
      end
      if (!found) begin
        vectors++; miscompares++; $display("FAIL restart_timeout%0d: got no fetch expected fetch", ph);
      end
      if (ph == 1) begin
        clk_step(1'b0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
          miscompares++; $display("FAIL restart_fetch: got %h expected %h", dut_vec, exp_vec());
        end
        restart_i = 1'b1;
      end else if (ph == 2) begin
        rst_n = 1'b0;
      end
      clk_step(1'b1);
      restart_i = 1'b0;
      rst_n = 1'b1;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL restart_apply%0d: got %h expected %h", ph, dut_vec, exp_vec());
      end
      if (ph > 0) begin
        vectors++;
        if (songpos_o !== 9'd287 || mel_vol_o !== 6'd0 || bass_vol_o !== 6'd0 ||
            step_o !== 1'b0 || rom_rd_o !== 1'b0) begin
          miscompares++;
          $display("FAIL restart_state%0d: got pos=%0d mv=%0d bv=%0d step=%b rd=%b expected 287 0 0 0 0",
                   ph, songpos_o, mel_vol_o, bass_vol_o, step_o, rom_rd_o);
        end
      end
      for (int c = 0; c < 6; c++) begin
        clk_step(1'b0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
          miscompares++; $display("FAIL restart_after%0d: got %h expected %h", ph, dut_vec, exp_vec());
        end
        if (ph > 0 && step_o !== 1'b0) begin
          vectors++; miscompares++; $display("FAIL restart_nostep%0d: got step=1 expected 0", ph);
        end
      end
    end
  endtask

  task automatic test_fetch_tick();
    bit found = 1'b0;
    int nxt = (m_pos + 1) % SONG_LEN;
    for (int i = 0; i < SONG_LEN; i++) rom[i] = 12'($urandom) & 12'h7DF;
    rom[nxt] = rom[nxt] | 12'h820;
    run_i = 1'b1;
    for (int c = 0; c < 200 && !found; c++) begin
      clk_step((c % 4) == 0);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL ftick_seek: got %h expected %h", dut_vec, exp_vec());
      end
      if (m_pend == 3) found = 1'b1;
    end
    if (!found) begin
      vectors++; miscompares++; $display("FAIL ftick_timeout: got no fetch expected fetch");
    end
    clk_step(1'b1);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL ftick_latch: got %h expected %h", dut_vec, exp_vec());
      end
      clk_step(1'b0);
    end
    vectors++;
    if (mel_vol_o !== 6'd63 || bass_vol_o !== 6'd63) begin
      miscompares++; $display("FAIL ftick_trig: got mv=%0d bv=%0d expected 63 63", mel_vol_o, bass_vol_o);
    end
    for (int k = 0; k < 46; k++) begin
      clk_step(1'b1);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++; $display("FAIL ftick_tick%0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      if (k < 6) begin
        vectors++;
        if (rom_rd_o !== (k == 5)) begin
          miscompares++; $display("FAIL ftick_count%0d: got rd=%b expected %b", k, rom_rd_o, k == 5);
        end
      end
      for (int c = 0; c < 3; c++) begin
        clk_step(1'b0);
        vectors++;
        if (dut_vec !== exp_vec()) begin
          miscompares++; $display("FAIL ftick_gap: got %h expected %h", dut_vec, exp_vec());
        end
      end
    end
    vectors++;
    if (mel_vol_o !== 6'd7 || bass_vol_o !== 6'd3) begin
      miscompares++; $display("FAIL ftick_floor: got mv=%0d bv=%0d expected 7 3", mel_vol_o, bass_vol_o);
    end
  endtask

  initial begin
    for (int i = 0; i < SONG_LEN; i++) rom[i] = 12'($urandom);
    test_reset();
    test_first_step();
    test_decay();
    test_pause();
    test_wrap();
    test_random();
    test_restart();
    test_fetch_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
